// File: rtl/dac_ltc2624_ctrl.sv
// LTC2624 DAC update controller: latches one request on a dactrig rising
// edge and shifts it out as a 32-bit SPI frame, then holds CS high for a
// minimum gap before the next request can be accepted.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | CS high, waiting for a dactrig rising edge
// S_SCK_LO | SCK low phase, MOSI carries the current bit
// S_SCK_HI | SCK high phase, DAC samples MOSI on the rising edge
// S_HOLD   | last bit shifted, CS held low one more half period
// S_GAP    | CS high, busy still asserted until the gap expires
module dac_ltc2624_ctrl #(
    parameter int DIV = 2,
    parameter int GAP = 4
) (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic [11:0] data,
    input  logic [3:0]  address,
    input  logic [3:0]  command,
    input  logic        dactrig,
    output logic        dacdone,
    output logic        busy,
    output logic        SPI_SCK,
    output logic        SPI_MOSI,
    output logic        DAC_CS,
    output logic        DAC_CLR
);

    localparam int DW = $clog2(DIV) + 1;
    localparam int GW = $clog2(GAP) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCK_LO,
        S_SCK_HI,
        S_HOLD,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [4:0]    bit_q, bit_d;
    logic [30:0]   shift_q, shift_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;
    logic          cs_q, cs_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          clr_q;
    logic          trig_q;

    logic [31:0]   frame_w;
    logic          start_w;

    assign frame_w = {8'h00, command, address, data, 4'h0};
    assign start_w = dactrig & ~trig_q & (state_q == S_IDLE);

    // Next-state and output decode; outputs are registered so the pins are glitch-free.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                cs_d   = 1'b1;
                sck_d  = 1'b0;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                if (start_w) begin
                    shift_d = frame_w[30:0];
                    mosi_d  = frame_w[31];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = 5'd31;
                    div_d   = DIV_LAST;
                    state_d = S_SCK_LO;
                end
            end
            S_SCK_LO: begin
                if (div_q == '0) begin
                    sck_d   = 1'b1;
                    div_d   = DIV_LAST;
                    state_d = S_SCK_HI;
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            S_SCK_HI: begin
                if (div_q == '0) begin
                    sck_d = 1'b0;
                    div_d = DIV_LAST;
                    if (bit_q == 5'd0) begin
                        state_d = S_HOLD;
                    end else begin
                        // Next bit changes on the falling edge so it is stable for the whole high phase.
                        bit_d   = bit_q - 5'd1;
                        mosi_d  = shift_q[30];
                        shift_d = {shift_q[29:0], 1'b0};
                        state_d = S_SCK_LO;
                    end
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            S_HOLD: begin
                if (div_q == '0) begin
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    gap_d   = GAP_LAST;
                    state_d = S_GAP;
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight without a done pulse.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            gap_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            clr_q   <= 1'b0;
            // Treat the trigger as already high so a level held through reset is not an edge.
            trig_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            clr_q   <= 1'b1;
            trig_q  <= dactrig;
        end
    end

    assign dacdone  = done_q;
    assign busy     = busy_q;
    assign SPI_SCK  = sck_q;
    assign SPI_MOSI = mosi_q;
    assign DAC_CS   = cs_q;
    assign DAC_CLR  = clr_q;

endmodule

// File: tb/tb_dac_ltc2624_ctrl.sv
// Bench for dac_ltc2624_ctrl: instance 0 uses default timing (DIV=2, GAP=4),
// instance 1 uses DIV=1, GAP=1. Stimulus pushes expected frames into a
// per-instance queue; a per-instance monitor decodes the SPI pins and
// compares when dacdone is seen.
module tb_dac_ltc2624_ctrl;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        trig_a, trig_b;
    logic [11:0] data;
    logic [3:0]  address;
    logic [3:0]  command;

    logic done_a, busy_a, sck_a, mosi_a, cs_a, clr_a;
    logic done_b, busy_b, sck_b, mosi_b, cs_b, clr_b;

    logic [1:0] done_v, busy_v, sck_v, mosi_v, cs_v, clr_v;
    assign done_v = {done_b, done_a};
    assign busy_v = {busy_b, busy_a};
    assign sck_v  = {sck_b,  sck_a};
    assign mosi_v = {mosi_b, mosi_a};
    assign cs_v   = {cs_b,   cs_a};
    assign clr_v  = {clr_b,  clr_a};

    int n_tests = 0;
    int n_fail  = 0;
    int ndone[2];
    int mosi_err[2];
    logic [31:0] exp_q[2][$];

    always #10 clk = ~clk;

    dac_ltc2624_ctrl #(.DIV(2), .GAP(4)) u_dut_a (
        .CLK50MHZ(clk), .RST(rst_a), .data(data), .address(address),
        .command(command), .dactrig(trig_a), .dacdone(done_a), .busy(busy_a),
        .SPI_SCK(sck_a), .SPI_MOSI(mosi_a), .DAC_CS(cs_a), .DAC_CLR(clr_a)
    );

    dac_ltc2624_ctrl #(.DIV(1), .GAP(1)) u_dut_b (
        .CLK50MHZ(clk), .RST(rst_b), .data(data), .address(address),
        .command(command), .dactrig(trig_b), .dacdone(done_b), .busy(busy_b),
        .SPI_SCK(sck_b), .SPI_MOSI(mosi_b), .DAC_CS(cs_b), .DAC_CLR(clr_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int g, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done_v[g]) seen = 1;
        end
        check($sformatf("dut%0d_done_timeout", g), 64'(seen), 64'd1);
    endtask

    task automatic wait_idle(input int g, input int budget);
        bit idle = 0;
        for (int i = 0; i < budget && !idle; i++) begin
            tick();
            if (!busy_v[g]) idle = 1;
        end
        check($sformatf("dut%0d_idle_timeout", g), 64'(idle), 64'd1);
    endtask

    // Per-instance SPI monitor / scoreboard.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        localparam int MDIV = (g == 0) ? 2 : 1;
        localparam int MGAP = (g == 0) ? 4 : 1;
        initial begin
            logic [31:0] sh, exp;
            int t, bits, first, gcnt;
            bit active, chk_w, in_gap;
            logic prev_sck, prev_cs;
            sh = '0; t = 0; bits = 0; first = -1; gcnt = 0;
            active = 0; chk_w = 0; in_gap = 0;
            prev_sck = 1'b0; prev_cs = 1'b1;
            ndone[g] = 0; mosi_err[g] = 0;
            forever begin
                tick();
                if (cs_v[g] == 1'b0 && prev_cs == 1'b1) begin
                    t = 0; bits = 0; sh = '0; first = -1; active = 1;
                end else if (active) begin
                    t++;
                end
                if (active && cs_v[g] == 1'b0 && sck_v[g] && !prev_sck) begin
                    if (bits == 0) first = t;
                    sh = {sh[30:0], mosi_v[g]};
                    bits++;
                end
                if (cs_v[g] && mosi_v[g]) mosi_err[g]++;
                if (chk_w) begin
                    check($sformatf("dut%0d_done_width", g), 64'(done_v[g]), 64'd0);
                    chk_w = 0;
                end
                if (in_gap) begin
                    gcnt++;
                    if (!busy_v[g]) begin
                        check($sformatf("dut%0d_gap_len", g), 64'(gcnt), 64'(MGAP));
                        in_gap = 0;
                    end else if (gcnt > 100) begin
                        check($sformatf("dut%0d_gap_timeout", g), 64'(gcnt), 64'(MGAP));
                        in_gap = 0;
                    end
                end
                if (done_v[g]) begin
                    ndone[g]++;
                    if (exp_q[g].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL dut%0d_unexpected_done: got frame %08h, expected none", g, sh);
                    end else begin
                        exp = exp_q[g].pop_front();
                        check($sformatf("dut%0d_frame", g), 64'(sh), 64'(exp));
                    end
                    check($sformatf("dut%0d_bits", g), 64'(bits), 64'd32);
                    check($sformatf("dut%0d_cs_low_len", g), 64'(t), 64'(65 * MDIV));
                    check($sformatf("dut%0d_first_rise", g), 64'(first), 64'(MDIV));
                    check($sformatf("dut%0d_cs_at_done", g), 64'(cs_v[g]), 64'd1);
                    check($sformatf("dut%0d_busy_at_done", g), 64'(busy_v[g]), 64'd1);
                    active = 0; chk_w = 1; in_gap = 1; gcnt = 0;
                end else if (cs_v[g] && !prev_cs) begin
                    active = 0;
                end
                prev_sck = sck_v[g];
                prev_cs  = cs_v[g];
            end
        end
    end

    initial begin
        rst_a = 1'b1; trig_a = 1'b1;
        rst_b = 1'b1; trig_b = 1'b0;
        data = 12'h000; address = 4'h0; command = 4'h0;

        // Reset with trigger held high.
        tick();
        check("rst_cs", 64'(cs_a), 64'd1);
        check("rst_sck", 64'(sck_a), 64'd0);
        check("rst_clr", 64'(clr_a), 64'd0);
        check("rst_mosi_busy_done", 64'({mosi_a, busy_a, done_a}), 64'd0);
        tick(); tick();
        rst_a = 1'b0;
        tick();
        check("clr_after_rst", 64'(clr_a), 64'd1);
        for (int i = 0; i < 10; i++) tick();
        check("no_start_held_trig", 64'({busy_a, cs_a}), 64'b01);
        trig_a = 1'b0;
        tick(); tick();

        // Basic frame, trigger pulsed two cycles.
        data = 12'h5F3; address = 4'h0; command = 4'h3;
        exp_q[0].push_back(32'h00305F30);
        trig_a = 1'b1; tick(); tick(); trig_a = 1'b0;
        wait_done(0, 400);

        // Trigger inside the gap is ignored, then a back-to-back frame.
        trig_a = 1'b1; tick(); trig_a = 1'b0;
        wait_idle(0, 50);
        tick(); tick(); tick();
        check("gap_trig_ignored", 64'({busy_a, cs_a}), 64'b01);
        data = 12'h3F5;
        exp_q[0].push_back(32'h00303F50);
        trig_a = 1'b1; tick(); tick(); trig_a = 1'b0;
        wait_done(0, 400);
        wait_idle(0, 50);
        tick();

        // Extra edge and input changes mid-frame.
        data = 12'hA5C; address = 4'h2; command = 4'h3;
        exp_q[0].push_back(32'h0032A5C0);
        trig_a = 1'b1; tick(); tick(); trig_a = 1'b0;
        for (int i = 0; i < 38; i++) tick();
        data = 12'hFFF; address = 4'hF; command = 4'hF;
        trig_a = 1'b1; tick(); trig_a = 1'b0;
        wait_done(0, 400);
        wait_idle(0, 50);
        tick();

        // Reset around bit 20 aborts the frame.
        data = 12'h123; address = 4'h1; command = 4'h3;
        trig_a = 1'b1; tick(); tick(); trig_a = 1'b0;
        for (int i = 0; i < 78; i++) tick();
        rst_a = 1'b1;
        tick();
        check("abort_cs", 64'(cs_a), 64'd1);
        check("abort_sck", 64'(sck_a), 64'd0);
        check("abort_busy_done", 64'({busy_a, done_a, mosi_a}), 64'd0);
        rst_a = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("abort_no_done", 64'(ndone[0]), 64'd3);
        data = 12'h5F3; address = 4'h0; command = 4'h3;
        exp_q[0].push_back(32'h00305F30);
        trig_a = 1'b1; tick(); tick(); trig_a = 1'b0;
        wait_done(0, 400);
        wait_idle(0, 50);

        // DIV=1, GAP=1 instance.
        rst_b = 1'b0;
        tick();
        check("b_clr_after_rst", 64'(clr_b), 64'd1);
        tick();
        exp_q[1].push_back(32'h00305F30);
        trig_b = 1'b1; tick(); trig_b = 1'b0;
        wait_done(1, 200);
        wait_idle(1, 50);
        tick(); tick();

        check("dut0_done_count", 64'(ndone[0]), 64'd4);
        check("dut1_done_count", 64'(ndone[1]), 64'd1);
        check("dut0_queue_empty", 64'(exp_q[0].size()), 64'd0);
        check("dut1_queue_empty", 64'(exp_q[1].size()), 64'd0);
        check("dut0_mosi_idle", 64'(mosi_err[0]), 64'd0);
        check("dut1_mosi_idle", 64'(mosi_err[1]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
